// File: rtl/cfg_sync_pkg.sv
// Shared constants and helpers for the configuration-bus synchroniser.
package cfg_sync_pkg;

    localparam int MODE_CONTINUOUS = 0;
    localparam int MODE_REQUEST    = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Width of a counter that must hold 0..stable_count inclusive.
    function automatic int cnt_width(input int stable_count);
        return (stable_count < 1) ? 1 : $clog2(stable_count + 1);
    endfunction

endpackage

// File: rtl/cfg_sync_stage.sv
// Synchroniser chain plus stability qualifier for a quasi-static bus.
module cfg_sync_stage
    import cfg_sync_pkg::*;
#(
    parameter int WIDTH        = 97,
    parameter int SYNC_DEPTH   = 3,
    parameter int STABLE_COUNT = 2
) (
    input  logic             spi_clk,
    input  logic             spi_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sync_q,
    output logic             stable
);

    localparam int CW = cnt_width(STABLE_COUNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_COUNT);

    logic [WIDTH-1:0] chain [SYNC_DEPTH];
    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    cnt;

    // Multi-flop synchroniser for the asynchronous bus.
    always_ff @(posedge spi_clk) begin
        if (spi_rst) begin
            for (int i = 0; i < SYNC_DEPTH; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < SYNC_DEPTH; i++) chain[i] <= chain[i-1];
        end
    end

    assign sync_q = chain[SYNC_DEPTH-1];

    // Count consecutive equal samples, saturating at the stability target.
    always_ff @(posedge spi_clk) begin
        if (spi_rst) begin
            prev <= '0;
            cnt  <= '0;
        end else begin
            prev <= sync_q;
            if (sync_q != prev) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // The counter lags sync_q by one compare; also requiring sync_q == prev
    // stops a fresh change from being committed while cnt is still saturated.
    assign stable = (cnt == CNT_MAX) && (sync_q == prev);

endmodule

// File: rtl/cfg_bus_sync.sv
// Configuration-bus synchroniser: stability-qualified commit, request mode,
// lock, fast disable, change pulse and stability-timeout flag.
//   state   | meaning
//   ST_IDLE | no snapshot requested (REQUEST mode)
//   ST_WAIT | snapshot requested, waiting for a commit
module cfg_bus_sync
    import cfg_sync_pkg::*;
#(
    parameter int DATA_W       = 96,
    parameter int SYNC_DEPTH   = 3,
    parameter int STABLE_COUNT = 2,
    parameter int MODE         = 0,
    parameter int TIMEOUT      = 1024
) (
    input  logic              spi_clk,
    input  logic              spi_rst,
    input  logic [DATA_W-1:0] cfg_in,
    input  logic              en_in,
    input  logic              lock,
    input  logic              req,
    output logic              ack,
    input  logic              err_clr,
    output logic [DATA_W-1:0] cfg_out,
    output logic              en_out,
    output logic              cfg_valid,
    output logic              cfg_update,
    output logic              unstable_err
);

    localparam int UW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [UW-1:0] UMAX = UW'(TIMEOUT);

    logic [DATA_W:0]   sync_q;
    logic              stable;
    logic              en_sync;
    logic [DATA_W-1:0] cfg_sync;
    logic              go;
    logic              dis_commit;
    logic              en_commit;
    logic              changed;
    logic              changed_q;
    logic              ack_nxt;
    logic              err_set;
    state_t            state;
    state_t            state_nxt;
    logic [UW-1:0]     ucnt;
    logic [UW-1:0]     ucnt_nxt;

    cfg_sync_stage #(
        .WIDTH        (DATA_W + 1),
        .SYNC_DEPTH   (SYNC_DEPTH),
        .STABLE_COUNT (STABLE_COUNT)
    ) u_stage (
        .spi_clk (spi_clk),
        .spi_rst (spi_rst),
        .d       ({en_in, cfg_in}),
        .sync_q  (sync_q),
        .stable  (stable)
    );

    assign en_sync    = sync_q[DATA_W];
    assign cfg_sync   = sync_q[DATA_W-1:0];
    assign go         = (MODE == MODE_REQUEST) ? (state == ST_WAIT) : 1'b1;
    assign dis_commit = stable && !en_sync;
    assign en_commit  = stable && en_sync && !lock && go;
    assign changed    = (en_commit && (!en_out || (cfg_sync != cfg_out)))
                      || (dis_commit && en_out);

    // Snapshot FSM next state; lock keeps a pending request parked in WAIT.
    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        case (state)
            ST_IDLE: if (req) state_nxt = ST_WAIT;
            ST_WAIT: if (en_commit || (dis_commit && !lock)) begin
                state_nxt = ST_IDLE;
                ack_nxt   = 1'b1;
            end
        endcase
    end

    // FSM state and acknowledge register; inert in CONTINUOUS mode.
    always_ff @(posedge spi_clk) begin
        if (spi_rst) begin
            state <= ST_IDLE;
            ack   <= 1'b0;
        end else begin
            state <= (MODE == MODE_REQUEST) ? state_nxt : ST_IDLE;
            ack   <= (MODE == MODE_REQUEST) && ack_nxt;
        end
    end

    // Committed configuration; disable only clears the enable, cfg is held.
    always_ff @(posedge spi_clk) begin
        if (spi_rst) begin
            cfg_out   <= '0;
            en_out    <= 1'b0;
            cfg_valid <= 1'b0;
        end else if (en_commit) begin
            cfg_out   <= cfg_sync;
            en_out    <= 1'b1;
            cfg_valid <= 1'b1;
        end else if (dis_commit) begin
            en_out    <= 1'b0;
        end
    end

    // Change pulse lands one edge after the committing edge.
    always_ff @(posedge spi_clk) begin
        if (spi_rst) begin
            changed_q  <= 1'b0;
            cfg_update <= 1'b0;
        end else begin
            changed_q  <= changed;
            cfg_update <= changed_q;
        end
    end

    // Unstable-cycle counter, saturating at TIMEOUT.
    always_comb begin
        ucnt_nxt = ucnt;
        if (stable) begin
            ucnt_nxt = '0;
        end else if (ucnt != UMAX) begin
            ucnt_nxt = ucnt + 1'b1;
        end
    end

    assign err_set = (TIMEOUT != 0) && !stable && (ucnt_nxt == UMAX);

    // Counter register and sticky error; a coincident set beats the clear.
    always_ff @(posedge spi_clk) begin
        if (spi_rst) begin
            ucnt         <= '0;
            unstable_err <= 1'b0;
        end else begin
            ucnt <= ucnt_nxt;
            if (err_set) begin
                unstable_err <= 1'b1;
            end else if (err_clr) begin
                unstable_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cfg_bus_sync.sv
// Bench for cfg_bus_sync: a CONTINUOUS and a REQUEST instance share stimulus;
// every cycle both are compared against a sample-history reference model.
module tb_cfg_bus_sync;

    localparam int DW = 12;
    localparam int D  = 3;
    localparam int S  = 2;
    localparam int T  = 16;

    logic          spi_clk = 1'b0;
    logic          spi_rst, en_in, lock, req, err_clr;
    logic [DW-1:0] cfg_in;

    logic          c_ack, c_en_out, c_valid, c_upd, c_err;
    logic [DW-1:0] c_cfg_out;
    logic          r_ack, r_en_out, r_valid, r_upd, r_err;
    logic [DW-1:0] r_cfg_out;

    always #5 spi_clk = ~spi_clk;

    cfg_bus_sync #(.DATA_W(DW), .SYNC_DEPTH(D), .STABLE_COUNT(S), .MODE(0), .TIMEOUT(T)) u_cont (
        .spi_clk(spi_clk), .spi_rst(spi_rst), .cfg_in(cfg_in), .en_in(en_in),
        .lock(lock), .req(req), .ack(c_ack), .err_clr(err_clr),
        .cfg_out(c_cfg_out), .en_out(c_en_out), .cfg_valid(c_valid),
        .cfg_update(c_upd), .unstable_err(c_err));

    cfg_bus_sync #(.DATA_W(DW), .SYNC_DEPTH(D), .STABLE_COUNT(S), .MODE(1), .TIMEOUT(T)) u_req (
        .spi_clk(spi_clk), .spi_rst(spi_rst), .cfg_in(cfg_in), .en_in(en_in),
        .lock(lock), .req(req), .ack(r_ack), .err_clr(err_clr),
        .cfg_out(r_cfg_out), .en_out(r_en_out), .cfg_valid(r_valid),
        .cfg_update(r_upd), .unstable_err(r_err));

    typedef struct {
        logic [DW-1:0] cfg;
        bit en, valid, upd1, upd, ack, err, wt;
        int ucnt;
    } mdl_t;

    typedef struct {
        logic [DW-1:0] cfg_i;
        bit            en_i;
        logic [DW-1:0] cfg_o;
        bit            en_o;
        bit            upd_o;
        bit            val_o;
    } vec_t;

    mdl_t          mc, mr;
    logic [DW:0]   hist[$];
    int            r_last;
    int            n_cmp, n_bad;
    vec_t          vec[9];
    logic [DW-1:0] pool[4];

    function automatic mdl_t mzero();
        mdl_t z;
        z.cfg = '0; z.en = 0; z.valid = 0; z.upd1 = 0; z.upd = 0;
        z.ack = 0; z.err = 0; z.wt = 0; z.ucnt = 0;
        return z;
    endfunction

    // Stable at edge k: the S+2 synchronised samples ending with the one
    // presented at edge k all agree, and S edges have passed since reset.
    function automatic bit stab_for(int k);
        if (k - 1 - r_last < S) return 1'b0;
        if (k - S - D - 1 < 0) return 1'b0;
        for (int i = k - S - D - 1; i <= k - D; i++)
            if (hist[i] != hist[k-D]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic mdl_t mnext(mdl_t s, int mode, bit stab, logic [DW:0] v,
                                   bit lk, bit rq, bit clr, bit rst);
        mdl_t n;
        bit dis, enb, chg;
        if (rst) return mzero();
        n   = s;
        dis = stab && !v[DW];
        enb = stab && v[DW] && !lk && (mode == 0 || s.wt);
        chg = (enb && (!s.en || s.cfg != v[DW-1:0])) || (dis && s.en);
        n.upd  = s.upd1;
        n.upd1 = chg;
        if (enb) begin n.cfg = v[DW-1:0]; n.en = 1; n.valid = 1; end
        else if (dis) n.en = 0;
        n.ack = 0;
        if (mode == 1) begin
            if (s.wt) begin
                if (enb || (dis && !lk)) begin n.ack = 1; n.wt = 0; end
            end else if (rq) n.wt = 1;
        end
        n.ucnt = stab ? 0 : ((s.ucnt + 1 > T) ? T : s.ucnt + 1);
        if (!stab && n.ucnt == T) n.err = 1;
        else if (clr) n.err = 0;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        int k;
        bit st;
        logic [DW:0] v;
        @(posedge spi_clk);
        k  = hist.size();
        st = spi_rst ? 1'b0 : stab_for(k);
        v  = (k >= D) ? hist[k-D] : '0;
        mc = mnext(mc, 0, st, v, lock, req, err_clr, spi_rst);
        mr = mnext(mr, 1, st, v, lock, req, err_clr, spi_rst);
        if (spi_rst) begin hist.push_back('0); r_last = k; end
        else hist.push_back({en_in, cfg_in});
        #1;
        chk("c_cfg", c_cfg_out, mc.cfg);  chk("c_en", c_en_out, mc.en);
        chk("c_valid", c_valid, mc.valid); chk("c_upd", c_upd, mc.upd);
        chk("c_ack", c_ack, 0);           chk("c_err", c_err, mc.err);
        chk("r_cfg", r_cfg_out, mr.cfg);  chk("r_en", r_en_out, mr.en);
        chk("r_valid", r_valid, mr.valid); chk("r_upd", r_upd, mr.upd);
        chk("r_ack", r_ack, mr.ack);      chk("r_err", r_err, mr.err);
    endtask

    initial begin
        int acks;
        int hold;
        n_cmp = 0; n_bad = 0; r_last = 0;
        mc = mzero(); mr = mzero();
        spi_rst = 1; cfg_in = '0; en_in = 0; lock = 0; req = 0; err_clr = 0;
        pool[0] = 12'h0A5; pool[1] = 12'h123; pool[2] = 12'h456; pool[3] = 12'hFFF;
        for (int i = 0; i < 6; i++) vec[i] = '{12'h0A5, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0};
        vec[6] = '{12'h0A5, 1'b1, 12'h0A5, 1'b1, 1'b0, 1'b1};
        vec[7] = '{12'h0A5, 1'b1, 12'h0A5, 1'b1, 1'b1, 1'b1};
        vec[8] = '{12'h0A5, 1'b1, 12'h0A5, 1'b1, 1'b0, 1'b1};

        repeat (5) tick();
        chk("rst_cfg", c_cfg_out, 0); chk("rst_en", c_en_out, 0);
        chk("rst_valid", c_valid, 0);  chk("rst_ack", r_ack, 0);
        spi_rst = 0;
        repeat (10) tick();

        // Latency: step applied after edge 0, row i checked after edge i+1.
        for (int i = 0; i < 9; i++) begin
            cfg_in = vec[i].cfg_i; en_in = vec[i].en_i;
            tick();
            chk("lat_cfg", c_cfg_out, vec[i].cfg_o);
            chk("lat_en", c_en_out, vec[i].en_o);
            chk("lat_upd", c_upd, vec[i].upd_o);
            chk("lat_valid", c_valid, vec[i].val_o);
        end

        // Two-sample glitch is never committed.
        cfg_in = 12'hFFF; tick(); tick();
        cfg_in = 12'h0A5;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("glitch_cfg", c_cfg_out, 12'h0A5);
            chk("glitch_upd", c_upd, 0);
        end

        // Lock blocks enabling commits; disable still gets through.
        lock = 1; cfg_in = 12'h123;
        repeat (10) tick();
        chk("lock_cfg", c_cfg_out, 12'h0A5); chk("lock_en", c_en_out, 1);
        en_in = 0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("dis_en", c_en_out, (i < 7) ? 1 : 0);
            chk("dis_cfg", c_cfg_out, 12'h0A5);
        end
        en_in = 1;
        repeat (10) tick();
        chk("locked_en", c_en_out, 0);
        lock = 0;
        tick();
        chk("unlock_cfg", c_cfg_out, 12'h123); chk("unlock_en", c_en_out, 1);

        // Request mode: ack and commit two edges after req is sampled.
        cfg_in = 12'h456;
        repeat (10) tick();
        chk("req_pre_cfg", r_cfg_out, 0);
        req = 1; tick(); req = 0;
        chk("req_ack1", r_ack, 0);
        tick();
        chk("req_ack2", r_ack, 1); chk("req_cfg", r_cfg_out, 12'h456); chk("req_en", r_en_out, 1);
        tick();
        chk("req_ack3", r_ack, 0);
        lock = 1; acks = 0;
        req = 1; tick(); acks += int'(r_ack); req = 0; tick(); acks += int'(r_ack);
        req = 1; tick(); acks += int'(r_ack); req = 0;
        repeat (3) begin tick(); acks += int'(r_ack); end
        lock = 0;
        repeat (5) begin tick(); acks += int'(r_ack); end
        chk("req_in_wait_acks", acks, 1);
        cfg_in = 12'h789;
        repeat (12) tick();
        chk("noreq_cfg", r_cfg_out, 12'h456);

        // Timeout: toggle every cycle; flag rises after 16 unstable cycles.
        for (int i = 1; i <= 30; i++) begin
            cfg_in  = (i % 2 == 1) ? 12'h0F0 : 12'h789;
            err_clr = (i >= 21 && i <= 25);
            tick();
            if (i == 18) chk("tmo_early", c_err, 0);
            if (i == 19) chk("tmo_set", c_err, 1);
            if (i == 25) chk("tmo_set_wins", c_err, 1);
        end
        err_clr = 0;
        repeat (10) tick();
        chk("tmo_sticky", c_err, 1);
        err_clr = 1; tick(); err_clr = 0;
        chk("tmo_clr", c_err, 0);

        // Reset while a request is parked in WAIT drops it.
        cfg_in = 12'hABC; lock = 1;
        repeat (10) tick();
        req = 1; tick(); req = 0; tick();
        spi_rst = 1; acks = 0;
        repeat (5) begin tick(); acks += int'(r_ack); end
        chk("rst_mid_acks", acks, 0);
        chk("rst_mid_cfg", r_cfg_out, 0); chk("rst_mid_en", r_en_out, 0);
        chk("rst_mid_valid", r_valid, 0); chk("rst_mid_ccfg", c_cfg_out, 0);
        spi_rst = 0; lock = 0;
        repeat (10) tick();
        req = 1; tick(); req = 0;
        chk("post_rst_ack1", r_ack, 0);
        tick();
        chk("post_rst_ack2", r_ack, 1); chk("post_rst_cfg", r_cfg_out, 12'hABC);

        // Randomised traffic against the model.
        hold = 0;
        for (int n = 0; n < 500; n++) begin
            if (hold == 0) begin
                cfg_in = pool[$urandom_range(0, 3)];
                en_in  = ($urandom_range(0, 3) != 0);
                hold   = $urandom_range(1, 8);
            end
            hold--;
            lock    = ($urandom_range(0, 4) == 0);
            req     = ($urandom_range(0, 5) == 0);
            err_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) begin
                spi_rst = 1; repeat (5) tick(); spi_rst = 0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
